// File: rtl/c_memory_mp.sv
// Dual-port instruction/data memory with byte-enable writes,
// a write-protected instruction region and a post-reset clear sweep.
module c_memory_mp #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 10,
  parameter int PROT_EN        = 1,
  parameter int PROT_LO        = 0,
  parameter int PROT_HI        = 255,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_ready,
  output logic                inst_valid,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_we,
  input  logic [DATA_W/8-1:0] data_be,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_ready,
  output logic                data_valid,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_err,
  output logic                init_busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BE_W  = DATA_W / 8;

  localparam logic [ADDR_W-1:0] LO   = ADDR_W'(PROT_LO);
  localparam logic [ADDR_W-1:0] HI   = ADDR_W'(PROT_HI);
  localparam logic [ADDR_W-1:0] SPAN = HI - LO;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ptr;
  logic              inst_acc;
  logic              data_acc;
  logic              wr_prot;
  logic              wr_en;

  // Wrap-around range test avoids constant compares when PROT_LO is 0
  assign wr_prot  = (PROT_EN != 0) && ((data_addr - LO) <= SPAN);
  assign inst_acc = inst_req & inst_ready;
  assign data_acc = data_req & data_ready;
  assign wr_en    = data_acc & data_we & ~wr_prot;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      CLEAR: if (ptr == '1) state_nxt = RUN;
      RUN:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    inst_ready = 1'b0;
    data_ready = 1'b0;
    if (state == RUN) begin
      inst_ready = 1'b1;
      data_ready = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= '0;
      init_busy <= (CLEAR_ON_RESET != 0);
    end else if (state == CLEAR) begin
      ptr       <= ptr + 1'b1;
      init_busy <= (ptr != '1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR) begin
        mem[ptr] <= '0;
      end else if (wr_en) begin
        for (int b = 0; b < BE_W; b++) begin
          if (data_be[b]) mem[data_addr][8*b +: 8] <= data_wdata[8*b +: 8];
        end
      end
    end
  end

  // Reads sample the pre-edge word, so a colliding fetch sees old data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_valid <= 1'b0;
      inst_rdata <= '0;
      data_valid <= 1'b0;
      data_rdata <= '0;
      data_err   <= 1'b0;
    end else begin
      inst_valid <= inst_acc;
      data_valid <= data_acc;
      data_err   <= data_acc & data_we & wr_prot;
      if (inst_acc) inst_rdata <= mem[inst_addr];
      if (data_acc) data_rdata <= data_we ? '0 : mem[data_addr];
    end
  end

endmodule

// File: tb/tb_c_memory_mp.sv
// Directed bench for c_memory_mp: sweep, byte enables, protection,
// collisions, mid-sweep reset and back-to-back throughput.
module tb_c_memory_mp;

  logic        clk;
  logic        rst_n;
  logic        inst_req;
  logic [9:0]  inst_addr;
  logic        inst_ready;
  logic        inst_valid;
  logic [15:0] inst_rdata;
  logic        data_req;
  logic        data_we;
  logic [1:0]  data_be;
  logic [9:0]  data_addr;
  logic [15:0] data_wdata;
  logic        data_ready;
  logic        data_valid;
  logic [15:0] data_rdata;
  logic        data_err;
  logic        init_busy;

  int n_vec;
  int n_err;

  c_memory_mp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_ready (inst_ready),
    .inst_valid (inst_valid),
    .inst_rdata (inst_rdata),
    .data_req   (data_req),
    .data_we    (data_we),
    .data_be    (data_be),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_ready (data_ready),
    .data_valid (data_valid),
    .data_rdata (data_rdata),
    .data_err   (data_err),
    .init_busy  (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic ir, input logic [9:0] ia,
                      input logic dr, input logic dw,
                      input logic [1:0] be, input logic [9:0] da,
                      input logic [15:0] wd);
    inst_req   = ir;
    inst_addr  = ia;
    data_req   = dr;
    data_we    = dw;
    data_be    = be;
    data_addr  = da;
    data_wdata = wd;
    @(posedge clk);
    #1;
    inst_req = 1'b0;
    data_req = 1'b0;
    data_we  = 1'b0;
  endtask

  task automatic dread(input string tag, input logic [9:0] a,
                       input logic [15:0] exp);
    step(1'b0, '0, 1'b1, 1'b0, 2'b00, a, '0);
    check({tag, "_valid"}, {31'b0, data_valid}, 32'd1);
    check(tag, {16'b0, data_rdata}, {16'b0, exp});
  endtask

  task automatic dwrite(input string tag, input logic [9:0] a,
                        input logic [1:0] be, input logic [15:0] wd,
                        input logic exp_err);
    step(1'b0, '0, 1'b1, 1'b1, be, a, wd);
    check({tag, "_valid"}, {31'b0, data_valid}, 32'd1);
    check({tag, "_err"}, {31'b0, data_err}, {31'b0, exp_err});
    check({tag, "_rdata"}, {16'b0, data_rdata}, 32'd0);
  endtask

  // Counts busy cycles; optionally fires requests that must be ignored
  task automatic sweep(input string tag, input logic poke);
    int busy;
    int bad_rdy;
    int bad_vld;
    busy    = 0;
    bad_rdy = 0;
    bad_vld = 0;
    while (init_busy && busy < 3000) begin
      busy++;
      if (inst_ready || data_ready) bad_rdy++;
      if (inst_valid || data_valid) bad_vld++;
      inst_req  = poke;
      inst_addr = 10'(busy);
      data_req  = poke;
      data_addr = 10'(busy);
      @(posedge clk);
      #1;
    end
    inst_req = 1'b0;
    data_req = 1'b0;
    check({tag, "_busy_cycles"}, 32'(busy), 32'd1024);
    check({tag, "_ready_low"}, 32'(bad_rdy), 32'd0);
    check({tag, "_no_valid"}, 32'(bad_vld), 32'd0);
  endtask

  logic [9:0]  ia_tab [8];
  logic [15:0] id_tab [8];

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    inst_req   = 1'b0;
    inst_addr  = '0;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_be    = '0;
    data_addr  = '0;
    data_wdata = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, init_busy}, 32'd1);
    check("rst_ivalid", {31'b0, inst_valid}, 32'd0);
    check("rst_dvalid", {31'b0, data_valid}, 32'd0);
    check("rst_err", {31'b0, data_err}, 32'd0);
    check("rst_irdata", {16'b0, inst_rdata}, 32'd0);
    check("rst_drdata", {16'b0, data_rdata}, 32'd0);
    rst_n = 1'b1;
    sweep("sweep1", 1'b0);
    check("run_ready", {30'b0, inst_ready, data_ready}, 32'd3);

    dread("clr0", 10'd0, 16'h0000);
    dread("clr513", 10'd513, 16'h0000);
    dread("clr1023", 10'd1023, 16'h0000);

    dwrite("w300a", 10'd300, 2'b11, 16'hABCD, 1'b0);
    dread("r300a", 10'd300, 16'hABCD);
    dwrite("w300b", 10'd300, 2'b01, 16'h1234, 1'b0);
    dread("r300b", 10'd300, 16'hAB34);
    dwrite("w300z", 10'd300, 2'b00, 16'h5555, 1'b0);
    dread("r300z", 10'd300, 16'hAB34);

    dwrite("w255", 10'd255, 2'b11, 16'hFFFF, 1'b1);
    dread("r255", 10'd255, 16'h0000);
    dwrite("w0", 10'd0, 2'b11, 16'hFFFF, 1'b1);
    dread("r0", 10'd0, 16'h0000);
    dwrite("w256", 10'd256, 2'b11, 16'hFFFF, 1'b0);
    dread("r256", 10'd256, 16'hFFFF);
    step(1'b0, '0, 1'b0, 1'b0, 2'b00, '0, '0);
    check("idle_dvalid", {31'b0, data_valid}, 32'd0);
    check("idle_err", {31'b0, data_err}, 32'd0);

    dwrite("w400", 10'd400, 2'b11, 16'h1111, 1'b0);
    step(1'b1, 10'd400, 1'b1, 1'b1, 2'b11, 10'd400, 16'h2222);
    check("col_ivalid", {31'b0, inst_valid}, 32'd1);
    check("col_old", {16'b0, inst_rdata}, 32'h1111);
    check("col_dvalid", {31'b0, data_valid}, 32'd1);
    step(1'b1, 10'd400, 1'b0, 1'b0, 2'b00, '0, '0);
    check("col_new", {16'b0, inst_rdata}, 32'h2222);
    step(1'b1, 10'd300, 1'b1, 1'b0, 2'b00, 10'd300, '0);
    check("dual_i", {16'b0, inst_rdata}, 32'hAB34);
    check("dual_d", {16'b0, data_rdata}, 32'hAB34);

    ia_tab = '{10'd300, 10'd400, 10'd255, 10'd256,
               10'd0, 10'd513, 10'd1023, 10'd300};
    id_tab = '{16'hAB34, 16'h2222, 16'h0000, 16'hFFFF,
               16'h0000, 16'h0000, 16'h0000, 16'hAB34};
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        step(1'b1, ia_tab[i], 1'b1, 1'b1, 2'b11, 10'(600 + i),
             16'(16'h5A00 + i));
        check("tp_dw", {16'b0, data_rdata}, 32'd0);
      end else begin
        step(1'b1, ia_tab[i], 1'b1, 1'b0, 2'b00, 10'(600 + i - 1), '0);
        check("tp_dr", {16'b0, data_rdata}, 32'(16'h5A00 + i - 1));
      end
      check("tp_ivalid", {31'b0, inst_valid}, 32'd1);
      check("tp_dvalid", {31'b0, data_valid}, 32'd1);
      check("tp_idata", {16'b0, inst_rdata}, {16'b0, id_tab[i]});
    end
    step(1'b0, '0, 1'b0, 1'b0, 2'b00, '0, '0);
    check("tp_ivalid_end", {31'b0, inst_valid}, 32'd0);
    check("tp_dvalid_end", {31'b0, data_valid}, 32'd0);

    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (500) begin
      @(posedge clk);
      #1;
    end
    check("mid_busy", {31'b0, init_busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sweep("sweep2", 1'b1);
    dread("clr300", 10'd300, 16'h0000);
    dread("clr400", 10'd400, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/c_memory_mp.md
Name: c_memory_mp

Overview:
- Parametrised successor to the unified instruction/data memory.
- Single clock. One read-only instruction port and one read/write data port, both served in the same cycle.
- Adds request/valid handshakes, byte-enable writes, a write-protected instruction region, and a post-reset clear sweep that zeroes every word.
- Sits between the fetch stage and the load/store unit of the core.

Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8.
- ADDR_W, 10, word-address width; DEPTH = 2**ADDR_W words.
- PROT_EN, 1, 1 = enable write protection of [PROT_LO, PROT_HI].
- PROT_LO, 0, first protected word address (inclusive).
- PROT_HI, 255, last protected word address (inclusive).
- CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = skip the sweep.

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, synchronous active-low reset.
- inst_req, input, 1, instruction read request.
- inst_addr, input, ADDR_W, instruction word address.
- inst_ready, output, 1, request accepted this cycle.
- inst_valid, output, 1, inst_rdata valid.
- inst_rdata, output, DATA_W, fetched word.
- data_req, input, 1, data access request.
- data_we, input, 1, 1 = write, 0 = read.
- data_be, input, DATA_W/8, byte enables for writes; bit i controls bits [8i+7:8i].
- data_addr, input, ADDR_W, data word address.
- data_wdata, input, DATA_W, write data.
- data_ready, output, 1, request accepted this cycle.
- data_valid, output, 1, read data valid or write acknowledged.
- data_rdata, output, DATA_W, read data; 0 on a write acknowledge.
- data_err, output, 1, qualifies data_valid: the write was blocked by protection.
- init_busy, output, 1, clear sweep in progress.

Behaviour:
- Reset (rst_n=0 at a clk edge): every output resets to 0, except init_busy, which resets to CLEAR_ON_RESET. The sweep pointer resets to 0. Memory contents are not reset directly.
- FSM states:
  - CLEAR: writes 0 to word ptr each cycle and increments ptr. When ptr = DEPTH-1 has been written, go to RUN and deassert init_busy on the following cycle.
  - RUN: normal operation.
  - Reset always enters CLEAR when CLEAR_ON_RESET=1, otherwise RUN.
  - The sweep takes exactly DEPTH cycles. Reset asserted mid-sweep restarts it at ptr 0.
- In CLEAR: inst_ready=0 and data_ready=0. Requests are ignored, not queued.
- In RUN:
  - inst_ready = 1 and data_ready = 1 combinationally; there is no backpressure.
  - An accepted request at edge N produces valid=1 for exactly one cycle after edge N+1 (1-cycle latency). Back-to-back requests give valid every cycle.
  - Ports are independent; both may be accepted in the same cycle.
- Data write:
  - Only bytes with data_be=1 are updated; the other bytes keep their value.
  - be = 0 is a legal no-op write and is still acknowledged.
  - A write is protected when PROT_EN=1 and PROT_LO <= data_addr <= PROT_HI.
  - A protected write does not modify memory and returns data_valid=1 with data_err=1.
  - A write outside the protected range returns data_valid=1 with data_err=0.
  - data_err is 0 whenever data_valid is 0, and is 0 for reads.
- Data read: data_rdata = word at data_addr as it was before the edge.
- Collisions, same address, same cycle:
  - Data write with instruction read: inst_rdata returns the OLD word (read-before-write). The new value is visible from the next access.
  - Data read with instruction read: both ports return the same word.
- Outputs hold their last rdata value while valid=0. Only the valid signals are meaningful.
- Address arithmetic is unsigned ADDR_W bits. There is no out-of-range case because all addresses are within DEPTH.

Test Plan:
1. Reset sweep: hold rst_n=0 for 2 cycles, release. Expect init_busy=1 for exactly 1024 cycles and ready=0 throughout. Then read addresses 0, 513 and 1023; each returns 16'h0000.
2. Byte-enable write (PROT_EN=1, protected range 0..255):
   - Write 16'hABCD, be=2'b11 to addr 300; read back 16'hABCD.
   - Write 16'h1234, be=2'b01 to addr 300; read back 16'hAB34.
   - data_err=0 on both writes.
3. Protection: write 16'hFFFF to addr 255 -> data_valid=1, data_err=1; a later read of addr 255 returns 16'h0000. Write to addr 256 -> data_err=0.
4. Collision: with addr 400 = 16'h1111, issue an inst read of 400 and a data write of 16'h2222 to 400 in the same cycle. Expect inst_rdata=16'h1111; the next inst read of 400 returns 16'h2222.
5. Mid-sweep reset: assert rst_n=0 at sweep cycle 500 and release. Expect init_busy to stay high for a full 1024 further cycles; requests issued in that window receive no valid.
6. Throughput: 8 back-to-back inst reads and 8 interleaved data reads/writes. Expect valid on every cycle from cycle 1 to cycle 8 with the correct data, and no dropped responses.
